// File: rtl/gate_tt_pkg.sv
// Shared types and reference truth tables for the gate truth-table checker.
// Bit i of each table is the gate output for input vector i (vec[1]=a, vec[0]=b).
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } tt_state_e;

  localparam logic [3:0] NOR2_TT  = 4'b0001;
  localparam logic [3:0] AND2_TT  = 4'b1000;
  localparam logic [3:0] OR2_TT   = 4'b1110;
  localparam logic [3:0] NAND2_TT = 4'b0111;
  localparam logic [3:0] XOR2_TT  = 4'b0110;

endpackage

// File: rtl/tt_vec_seq.sv
// Vector sequencer for the checker: registered stimulus vector plus the
// per-vector settle countdown.
module tt_vec_seq #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  output logic [N_IN-1:0] vec_out,
  output logic            settle_zero,
  output logic            last_vec
);

  localparam int            CW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

  logic [N_IN-1:0] r_vec;
  logic [CW-1:0]   r_cnt;

  // load restarts at vector 0, step advances; both reload the settle count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec <= '0;
      r_cnt <= '0;
    end else if (load) begin
      r_vec <= '0;
      r_cnt <= RELOAD;
    end else if (step) begin
      r_vec <= r_vec + 1'b1;
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign vec_out     = r_vec;
  assign settle_zero = (r_cnt == '0);
  assign last_vec    = (r_vec == '1);

endmodule

// File: rtl/gate_tt_checker.sv
// Truth-table checker: walks every input vector of a small gate, compares its output
// with EXPECT_TT and counts mismatches. Optional first-fail capture: GATE_TT_CHECKER_FIRST_FAIL_EN.
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter int                   N_IN      = 2,
  parameter logic [2**N_IN-1:0]   EXPECT_TT = NOR2_TT,
  parameter int                   SETTLE    = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] vec_out,
  input  logic            dut_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
  output logic            first_fail_vld,
  output logic [N_IN-1:0] first_fail_vec,
`endif
  output logic [N_IN:0]   err_cnt
);

  tt_state_e       r_state;
  tt_state_e       w_next;
  logic            w_load;
  logic            w_step;
  logic            w_sample;
  logic            w_settle_zero;
  logic            w_last_vec;
  logic            w_mismatch;
  logic [N_IN-1:0] w_vec;
  logic [N_IN:0]   r_err;

  tt_vec_seq #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE)
  ) u_seq (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_load),
    .step        (w_step),
    .vec_out     (w_vec),
    .settle_zero (w_settle_zero),
    .last_vec    (w_last_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // start is honoured only when no run is in flight
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_sample = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = gate_tt_pkg::SETTLE;
          w_load = 1'b1;
        end
      end
      gate_tt_pkg::SETTLE: begin
        if (w_settle_zero) w_next = gate_tt_pkg::SAMPLE;
      end
      gate_tt_pkg::SAMPLE: begin
        w_sample = 1'b1;
        if (w_last_vec) begin
          w_next = DONE;
        end else begin
          w_step = 1'b1;
          w_next = gate_tt_pkg::SETTLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_mismatch = (dut_o != EXPECT_TT[w_vec]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   r_err <= '0;
    else if (w_load)                              r_err <= '0;
    else if (w_sample && w_mismatch && r_err != '1) r_err <= r_err + 1'b1;
  end

`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
  logic            r_ff_vld;
  logic [N_IN-1:0] r_ff_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else if (w_load) begin
      r_ff_vld <= 1'b0;
      r_ff_vec <= '0;
    end else if (w_sample && w_mismatch && !r_ff_vld) begin
      r_ff_vld <= 1'b1;
      r_ff_vec <= w_vec;
    end
  end

  assign first_fail_vld = r_ff_vld;
  assign first_fail_vec = r_ff_vec;
`endif

  assign vec_out = w_vec;
  assign busy    = (r_state == gate_tt_pkg::SETTLE) || (r_state == gate_tt_pkg::SAMPLE);
  assign done    = (r_state == DONE);
  assign pass    = (r_state == DONE) && (r_err == '0);
  assign err_cnt = r_err;

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker: a NOR2 or fault model drives dut_o from vec_out; a table of
// fault models, random gate tables and hand sequences cover mid-run start and reset abort.
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] gateTt0;
  logic [3:0] gateTt1;
  logic [1:0] vec0, vec1;
  logic       dutO0, dutO1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [2:0] err0, err1;
`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
  logic       ffVld0, ffVld1;
  logic [1:0] ffVec0, ffVec1;
`endif

  int total = 0;
  int bad   = 0;
  int sel   = 0;

  logic [1:0] selVec;
  logic       selBusy, selDone, selPass;
  logic [2:0] selErr;

  typedef struct {
    string      name;
    logic [3:0] gate;
    int         expErr;
    int         expFirst;
  } vecRec_t;

  vecRec_t tbl[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dutO0 = gateTt0[vec0];
  assign dutO1 = gateTt1[vec1];

  always_comb begin
    selVec  = (sel == 1) ? vec1  : vec0;
    selBusy = (sel == 1) ? busy1 : busy0;
    selDone = (sel == 1) ? done1 : done0;
    selPass = (sel == 1) ? pass1 : pass0;
    selErr  = (sel == 1) ? err1  : err0;
  end

  gate_tt_checker u_dut0 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vec_out        (vec0),
    .dut_o          (dutO0),
    .busy           (busy0),
    .done           (done0),
    .pass           (pass0),
`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
    .first_fail_vld (ffVld0),
    .first_fail_vec (ffVec0),
`endif
    .err_cnt        (err0)
  );

  gate_tt_checker #(.N_IN(2), .EXPECT_TT(AND2_TT), .SETTLE(3)) u_dut1 (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .vec_out        (vec1),
    .dut_o          (dutO1),
    .busy           (busy1),
    .done           (done1),
    .pass           (pass1),
`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
    .first_fail_vld (ffVld1),
    .first_fail_vec (ffVec1),
`endif
    .err_cnt        (err1)
  );

  // Reference: a mismatch is any vector where the gate's table disagrees with the expected table
  function automatic int refErrors(input logic [3:0] gate, input logic [3:0] expect_tt);
    int n = 0;
    for (int i = 0; i < 4; i++) if (gate[i] != expect_tt[i]) n++;
    return n;
  endfunction

  function automatic int refFirst(input logic [3:0] gate, input logic [3:0] expect_tt);
    for (int i = 0; i < 4; i++) if (gate[i] != expect_tt[i]) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Full run on the selected instance; pulseAt>=0 pulses start mid-run, abortAt>=0 resets
  task automatic runCheck(input string name, input int s, input int settle, input logic [3:0] gate,
                          input int expErr, input int expFirst, input int pulseAt);
    int runLen;
    int expVec;
    int vecBad;
    sel     = s;
    gateTt0 = gate;
    runLen  = 4 * (settle + 1);
    applyStimulus();
    checkOutput({name, " start busy"}, int'(selBusy), 1);
    checkOutput({name, " start done"}, int'(selDone), 0);
    checkOutput({name, " start err"}, int'(selErr), 0);
    vecBad = 0;
    for (int j = 1; j <= runLen; j++) begin
      @(posedge clk); #1;
      expVec = j / (settle + 1);
      if (expVec > 3) expVec = 3;
      if (int'(selVec) != expVec) vecBad++;
      if (j == runLen - 1) checkOutput({name, " done early"}, int'(selDone), 0);
      start = (j == pulseAt) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    checkOutput({name, " vec sequence errs"}, vecBad, 0);
    checkOutput({name, " done on time"}, int'(selDone), 1);
    checkOutput({name, " busy at done"}, int'(selBusy), 0);
    for (int w = 0; w < 40 && selDone !== 1'b1; w++) @(posedge clk);
    #1;
    checkOutput({name, " err_cnt"}, int'(selErr), expErr);
    checkOutput({name, " pass"}, int'(selPass), (expErr == 0) ? 1 : 0);
`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
    if (s == 0) begin
      checkOutput({name, " ff_vld"}, int'(ffVld0), (expFirst >= 0) ? 1 : 0);
      if (expFirst >= 0) checkOutput({name, " ff_vec"}, int'(ffVec0), expFirst);
    end
`endif
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] rg;
    tbl[0] = '{"nor2_ok",   4'b0001, 0, -1};
    tbl[1] = '{"stuck0",    4'b0000, 1,  0};
    tbl[2] = '{"stuck1",    4'b1111, 3,  1};
    tbl[3] = '{"inverted",  4'b1110, 4,  0};

    gateTt0 = NOR2_TT;
    gateTt1 = NOR2_TT;
    start   = 1'b0;
    rst_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset vec", int'(vec0), 0);
    checkOutput("reset busy", int'(busy0), 0);
    checkOutput("reset done", int'(done0), 0);
    checkOutput("reset pass", int'(pass0), 0);
    checkOutput("reset err", int'(err0), 0);
    #2 rst_n = 1'b1;

    for (int t = 0; t < 4; t++)
      runCheck(tbl[t].name, 0, 1, tbl[t].gate, tbl[t].expErr, tbl[t].expFirst, -1);

    for (int r = 0; r < 8; r++) begin
      rg = 4'($urandom_range(0, 15));
      runCheck("random", 0, 1, rg, refErrors(rg, NOR2_TT), refFirst(rg, NOR2_TT), -1);
    end

    // AND2 expectation against a good NOR2, with a longer settle time
    repeat (20) @(posedge clk);
    runCheck("and2_settle3", 1, 3, NOR2_TT, 2, -1, -1);
    repeat (20) @(posedge clk);

    // start pulsed while vector 2 is held must not restart the run
    runCheck("stuck0_midstart", 0, 1, 4'b0000, 1, 0, 4);
    runCheck("rerun_clean", 0, 1, NOR2_TT, 0, -1, -1);

    // reset while vector 1 is held: outputs drop before the next edge
    sel     = 0;
    gateTt0 = 4'b1111;
    applyStimulus();
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("abort pre vec", int'(vec0), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort vec", int'(vec0), 0);
    checkOutput("abort busy", int'(busy0), 0);
    checkOutput("abort done", int'(done0), 0);
    checkOutput("abort pass", int'(pass0), 0);
    checkOutput("abort err", int'(err0), 0);
`ifdef GATE_TT_CHECKER_FIRST_FAIL_EN
    checkOutput("abort ff_vld", int'(ffVld0), 0);
`endif
    #2 rst_n = 1'b1;
    runCheck("post_abort", 0, 1, NOR2_TT, 0, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
